// File: rtl/rr_pkg.sv
// Shared types, constants and rotation helper for the round-robin arbiter.
package rr_pkg;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // First set request scanning ptr+1, ptr+2, ptr+3, ptr (mod NREQ); returns ptr if req is empty.
  function automatic logic [IDX_W-1:0] rot_select(input logic [NREQ-1:0] req,
                                                  input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    rot_select = ptr;
    // Walk from the farthest offset down so the nearest set bit wins last.
    for (int k = NREQ; k >= 1; k--) begin
      idx = ptr + IDX_W'(k);
      if (req[idx]) rot_select = idx;
    end
  endfunction

endpackage

// File: rtl/onehot_enc4.sv
// Combinational 4-to-2 encoder with enable: one-hot d -> binary (a1,a0); 00 when disabled.
module onehot_enc4 (
  input  logic       en,
  input  logic [3:0] d,
  output logic [1:0] y
);

  // Encode assuming d is zero or one-hot.
  always_comb begin
    y = 2'b00;
    if (en) y = {d[3] | d[2], d[3] | d[1]};
  end

endmodule

// File: rtl/rr_enc_arbiter.sv
// Round-robin arbiter: four requesters, registered one-hot grant held until release,
// then one dead cycle and rotated priority.
// Optional hold-time limit with forced release: define RR_TIMEOUT_EN.
module rr_enc_arbiter
  import rr_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             done,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  // Reject configurations where the hold counter cannot reach HOLD_MAX-1.
  if (HOLD_MAX < 1 || HOLD_MAX > 255 || (64'(1) << CNT_W) <= 64'(HOLD_MAX)) begin : g_bad_cfg
    $error("rr_enc_arbiter: illegal HOLD_MAX/CNT_W combination");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] sel_c;
  logic             tmo_hit_c;

`ifdef RR_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  assign tmo_hit_c = (cnt_q == CNT_W'(HOLD_MAX - 1));
  assign timeout   = timeout_q;
`else
  assign tmo_hit_c = 1'b0;
  assign timeout   = 1'b0;
`endif

  assign sel_c = rot_select(req, ptr_q);

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= IDX_W'(NREQ - 1);
      gnt_q     <= '0;
      valid_q   <= 1'b0;
`ifdef RR_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      valid_q   <= valid_d;
`ifdef RR_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  // Next-state: grant on request in IDLE, release on done / dropped request / timeout.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    valid_d   = valid_q;
`ifdef RR_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          ptr_d   = sel_c;
          gnt_d   = NREQ'(1) << sel_c;
          valid_d = 1'b1;
`ifdef RR_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      GRANT: begin
`ifdef RR_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
`endif
        // ptr_q names the current owner for the whole grant.
        if (done || !req[ptr_q] || tmo_hit_c) begin
          state_d = IDLE;
          gnt_d   = '0;
          valid_d = 1'b0;
`ifdef RR_TIMEOUT_EN
          timeout_d = !done && req[ptr_q];
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Binary index of the registered grant.
  onehot_enc4 u_enc (
    .en (valid_q),
    .d  (gnt_q),
    .y  (gnt_idx)
  );

  assign gnt       = gnt_q;
  assign gnt_valid = valid_q;

endmodule
